spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI responder (target) end of the serial link driven by the team's SPI master controller.
- Oversamples external SCLK/CS_N/MOSI in the system clock domain and shifts received bits into a parallel word.
- Shifts a preloaded transmit word out on MISO.
- Offers a one-entry TX holding buffer (valid/ready) and a one-cycle RX strobe to the local register/logic side.

Parameters:
- DATA_W, 8, frame length in bits (legal 4..16).
- SYNC_STAGES, 2, synchronizer flops on spi_sclk, spi_cs_n and spi_mosi (legal 2..3).

Ports:
- clk  in  1  system clock; spi_sclk must be at most clk/8.
- reset_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  serial clock from the master.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data from the master.
- spi_miso  out  1  serial data to the master.
- spi_miso_oe  out  1  MISO output enable; pad tristates when 0.
- lsb_first  in  1  0 = MSB first, 1 = LSB first; sampled at frame start.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- tx_underrun  out  1  one-cycle strobe: frame started with the holding buffer empty.
- frame_err  out  1  one-cycle strobe: CS_N rose mid-frame.
- busy  out  1  high in the SHIFT state.

Behaviour:
Reset values:
- All outputs 0 except tx_ready = 1.
- Holding buffer empty, shifter 0, bit_cnt 0, state IDLE.

Input conditioning:
- Each SPI input passes through SYNC_STAGES flops.
- Edge detection compares the last synced stage with one extra delayed flop.
- Result: sclk_rise, sclk_fall, cs_fall, cs_rise, each one clk wide.

TX holding buffer:
- Accept on tx_valid && tx_ready; the buffer becomes full and tx_ready goes 0 the next cycle.
- Load into the shifter empties the buffer; tx_ready returns to 1 the next cycle.
- If a load and a new tx_valid coincide, the new word is not accepted, because tx_ready was 0 that cycle.

FSM (default mode 0, CPOL=0/CPHA=0):
- IDLE:
  - spi_miso_oe = 0, spi_miso = 0.
  - On cs_fall: latch lsb_first and load the shifter from the buffer if full; otherwise load all zeros and pulse tx_underrun.
  - Set bit_cnt = 0 and go to SHIFT.
- SHIFT:
  - spi_miso_oe = 1.
  - spi_miso = shifter bit 0 when lsb_first, else bit DATA_W-1.
  - sclk_rise: capture synced MOSI into the RX shift register (LSB-first inserts at the top and shifts right; MSB-first inserts at the bottom and shifts left); bit_cnt++.
  - sclk_fall: advance the TX shifter one bit.
  - bit_cnt reaching DATA_W on a rise:
    - rx_data is updated and rx_valid pulses on the next clk (latency SYNC_STAGES+2 clk from the pin edge).
    - bit_cnt clears.
    - If CS_N is still low, reload the TX shifter from the buffer (same underrun rule) on the following sclk_fall; this gives back-to-back frames.
  - cs_rise:
    - with bit_cnt = 0, return to IDLE silently;
    - with bit_cnt ≠ 0, discard partial bits, pulse frame_err, go to IDLE.
    - The buffer contents are kept.
- cs_rise and the final sclk_rise in the same cycle: the word completes (rx_valid) and no frame_err.
- Asynchronous reset mid-frame: immediate return to reset values, no strobes.

Optional Feature:
- Macro SPI_SLAVE_MODE_SEL_EN.
- When defined, adds input ports cpol (1 bit) and cpha (1 bit), sampled on cs_fall.
  - Leading/trailing edges are derived from cpol.
  - CPHA=0: sample on leading, shift on trailing, first bit valid at cs_fall.
  - CPHA=1: shift on leading (first leading edge presents bit 0), sample on trailing.
- When undefined, there are no extra ports and the block is fixed to mode 0 as above.

Decomposition:
- Package spi_pkg holds:
  - spi_slv_state_e enum {IDLE, SHIFT};
  - localparam SPI_SYNC_DEFAULT = 2;
  - typedef of the mode struct {cpol, cpha}.
- One sub-module, spi_sync_bit (SYNC_STAGES-deep synchronizer with reset value parameter), instantiated three times: reset value 1 for spi_cs_n, 0 for spi_sclk and spi_mosi.

Test Plan:
- Load tx_data=0xA5; master sends 0x3C MSB-first in mode 0 → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready returns to 1.
- lsb_first=1, tx=0x01, master sends 0x80 → first MISO bit 1; rx_data=0x80.
- No TX load; frame sent → tx_underrun pulses at cs_fall; MISO all 0; rx still correct.
- CS_N raised after 5 bits → frame_err pulse; no rx_valid; the next full frame with 0x55 is received correctly.
- Two back-to-back frames with CS_N held low, TX 0x11 then 0x22 loaded during frame 1 → MISO 0x11 then 0x22; two rx_valid pulses.
- Reset asserted mid-frame → all outputs at reset values within the same cycle; tx_ready=1.

Source files
------------

// File: rtl/spi_slave_if_pkg.sv
// Shared types for the SPI responder: FSM states, sync depth default and the clock-mode pair.
package spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_slv_state_e;

   localparam int unsigned SPI_SYNC_DEFAULT = 2;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pad bundle between a master and the responder.
interface spi_slave_if_if;
   logic spi_sclk;
   logic spi_cs_n;
   logic spi_mosi;
   logic spi_miso;
   logic spi_miso_oe;

   modport master (output spi_sclk, output spi_cs_n, output spi_mosi,
                   input  spi_miso, input  spi_miso_oe);
   modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_mosi,
                   output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_slave_if_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable reset value.
module spi_sync_bit
   import spi_pkg::*;
#(
   parameter int unsigned STAGES  = SPI_SYNC_DEFAULT,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr <= {STAGES{RST_VAL}};
      else          sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder: oversampled pins, RX shift/strobe, TX shifter fed by a one-entry holding buffer.
// Optional macro SPI_SLAVE_MODE_SEL_EN adds cpol/cpha ports; default build is fixed to mode 0.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   spi_slave_if_if.slave     spi,
`ifdef SPI_SLAVE_MODE_SEL_EN
   input  logic              cpol,
   input  logic              cpha,
`endif
   input  logic              lsb_first,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic sample_edge, shift_edge;

   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .d(spi.spi_sclk), .q(sclk_s));
   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset_n(reset_n), .d(spi.spi_cs_n), .q(cs_s));
   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .d(spi.spi_mosi), .q(mosi_s));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;

   spi_slv_state_e    state, state_nx;
   logic [CNT_W-1:0]  bit_cnt, cnt_nx;
   logic [DATA_W-1:0] tx_shift, tx_shift_nx, rx_shift, rx_shift_nx;
   logic [DATA_W-1:0] buf_data, buf_data_nx, rx_data_nx, load_word;
   logic              buf_full, buf_full_nx, lsb_q, lsb_nx;
   logic              reload_pend, reload_nx, word_done, done_nx, skip_shift, skip_nx;
   logic              rx_valid_nx, underrun_nx, frame_err_nx, miso_nx;
   logic              miso_q, miso_oe_q;

`ifdef SPI_SLAVE_MODE_SEL_EN
   spi_mode_t mode_q, mode_nx;
   logic      lead_edge, trail_edge;

   // Leading edge is the idle-to-active SCLK transition for the latched polarity.
   assign lead_edge   = mode_q.cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = mode_q.cpol ? sclk_rise : sclk_fall;
   assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
   assign shift_edge  = mode_q.cpha ? lead_edge : trail_edge;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mode_q <= '0;
      else          mode_q <= mode_nx;
   end
`else
   assign sample_edge = sclk_rise;
   assign shift_edge  = sclk_fall;
`endif

   // An empty buffer feeds zeros to the shifter and flags an underrun.
   assign load_word = buf_full ? buf_data : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = bit_cnt;
      tx_shift_nx  = tx_shift;
      rx_shift_nx  = rx_shift;
      buf_data_nx  = buf_data;
      buf_full_nx  = buf_full;
      lsb_nx       = lsb_q;
      reload_nx    = reload_pend;
      skip_nx      = skip_shift;
      done_nx      = 1'b0;
      rx_data_nx   = rx_data;
      rx_valid_nx  = 1'b0;
      underrun_nx  = 1'b0;
      frame_err_nx = 1'b0;
`ifdef SPI_SLAVE_MODE_SEL_EN
      mode_nx      = mode_q;
`endif

      if (tx_valid && tx_ready) begin
         buf_data_nx = tx_data;
         buf_full_nx = 1'b1;
      end

      // Completed word is published one cycle after its last bit, in any state.
      if (word_done) begin
         rx_data_nx  = rx_shift;
         rx_valid_nx = 1'b1;
      end

      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nx    = SHIFT;
               lsb_nx      = lsb_first;
               cnt_nx      = '0;
               reload_nx   = 1'b0;
               skip_nx     = 1'b0;
               tx_shift_nx = load_word;
               buf_full_nx = 1'b0;
               underrun_nx = ~buf_full;
`ifdef SPI_SLAVE_MODE_SEL_EN
               mode_nx     = '{cpol: cpol, cpha: cpha};
               skip_nx     = cpha;
`endif
            end
         end
         SHIFT: begin
            if (sample_edge) begin
               rx_shift_nx = lsb_q ? {mosi_s, rx_shift[DATA_W-1:1]}
                                   : {rx_shift[DATA_W-2:0], mosi_s};
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  cnt_nx    = '0;
                  done_nx   = 1'b1;
                  reload_nx = 1'b1;
               end else begin
                  cnt_nx = bit_cnt + CNT_W'(1);
               end
            end
            if (shift_edge) begin
               if (reload_pend) begin
                  reload_nx   = 1'b0;
                  tx_shift_nx = load_word;
                  buf_full_nx = 1'b0;
                  underrun_nx = ~buf_full;
               end else if (skip_shift) begin
                  skip_nx = 1'b0;
               end else begin
                  tx_shift_nx = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
               end
            end
            // A final bit landing with CS_N's rise leaves cnt_nx at zero: no error.
            if (cs_rise) begin
               state_nx     = IDLE;
               reload_nx    = 1'b0;
               frame_err_nx = (cnt_nx != '0);
               cnt_nx       = '0;
            end
         end
         default: state_nx = IDLE;
      endcase

      miso_nx = (state_nx == SHIFT) ? (lsb_nx ? tx_shift_nx[0] : tx_shift_nx[DATA_W-1]) : 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         buf_data    <= '0;
         buf_full    <= 1'b0;
         lsb_q       <= 1'b0;
         reload_pend <= 1'b0;
         skip_shift  <= 1'b0;
         word_done   <= 1'b0;
         tx_ready    <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         bit_cnt     <= cnt_nx;
         tx_shift    <= tx_shift_nx;
         rx_shift    <= rx_shift_nx;
         buf_data    <= buf_data_nx;
         buf_full    <= buf_full_nx;
         lsb_q       <= lsb_nx;
         reload_pend <= reload_nx;
         skip_shift  <= skip_nx;
         word_done   <= done_nx;
         tx_ready    <= ~buf_full_nx;
         rx_data     <= rx_data_nx;
         rx_valid    <= rx_valid_nx;
         tx_underrun <= underrun_nx;
         frame_err   <= frame_err_nx;
         busy        <= (state_nx == SHIFT);
         miso_q      <= miso_nx;
         miso_oe_q   <= (state_nx == SHIFT);
      end
   end

   assign spi.spi_miso    = miso_q;
   assign spi.spi_miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if in mode 0: table of frames plus hand-written corner sequences.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       lsb_first;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun, frame_err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rxv = 0;
   int n_und = 0;
   int n_ferr = 0;
   logic [7:0] last_rx = '0;

   spi_slave_if_if ifc ();

   spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .spi(ifc),
`ifdef SPI_SLAVE_MODE_SEL_EN
      .cpol(1'b0), .cpha(1'b0),
`endif
      .lsb_first(lsb_first), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
      .frame_err(frame_err), .busy(busy));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_rxv   <= n_rxv + 1;
         last_rx <= rx_data;
      end
      if (tx_underrun) n_und  <= n_und + 1;
      if (frame_err)   n_ferr <= n_ferr + 1;
   end

   typedef struct {
      logic [7:0] tx;
      bit         load;
      bit         lsb;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
      int         exp_und;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_word(input logic [7:0] w);
      int t = 0;
      while (!tx_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("load_ready", 32'(tx_ready), 32'd1);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Master side: drops CS_N if high, clocks nbits, samples MISO just before each rise.
   task automatic frame(input logic [7:0] mw, input int nbits, input bit raise,
                        output logic [7:0] sw, output int und);
      int u0;
      int idx;
      sw  = '0;
      und = 0;
      if (ifc.spi_cs_n) begin
         u0 = n_und;
         ifc.spi_cs_n = 1'b0;
         repeat (8) @(negedge clk);
         und = n_und - u0;
      end
      for (int i = 0; i < nbits; i++) begin
         idx = lsb_first ? i : 7 - i;
         ifc.spi_mosi = mw[idx];
         repeat (6) @(negedge clk);
         sw[idx] = ifc.spi_miso;
         ifc.spi_sclk = 1'b1;
         repeat (6) @(negedge clk);
         ifc.spi_sclk = 1'b0;
      end
      repeat (6) @(negedge clk);
      if (raise) begin
         ifc.spi_cs_n = 1'b1;
         repeat (10) @(negedge clk);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] m1, m2;
      int und, rxv0, ferr0;

      vecs[0] = '{tx: 8'hA5, load: 1'b1, lsb: 1'b0, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_und: 0};
      vecs[1] = '{tx: 8'h01, load: 1'b1, lsb: 1'b1, mosi: 8'h80, exp_miso: 8'h01, exp_rx: 8'h80, exp_und: 0};
      vecs[2] = '{tx: 8'h00, load: 1'b0, lsb: 1'b0, mosi: 8'h5A, exp_miso: 8'h00, exp_rx: 8'h5A, exp_und: 1};
      vecs[3] = '{tx: 8'hC3, load: 1'b1, lsb: 1'b1, mosi: 8'h96, exp_miso: 8'hC3, exp_rx: 8'h96, exp_und: 0};

      reset_n = 1'b0;
      lsb_first = 1'b0;
      tx_data = '0;
      tx_valid = 1'b0;
      ifc.spi_sclk = 1'b0;
      ifc.spi_cs_n = 1'b1;
      ifc.spi_mosi = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_miso_oe", 32'(ifc.spi_miso_oe), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         if (vecs[i].load) begin
            load_word(vecs[i].tx);
            check($sformatf("v%0d_ready_low", i), 32'(tx_ready), 32'd0);
         end
         lsb_first = vecs[i].lsb;
         rxv0  = n_rxv;
         ferr0 = n_ferr;
         frame(vecs[i].mosi, 8, 1'b1, m1, und);
         check($sformatf("v%0d_miso", i), 32'(m1), 32'(vecs[i].exp_miso));
         check($sformatf("v%0d_rx", i), 32'(last_rx), 32'(vecs[i].exp_rx));
         check($sformatf("v%0d_rxv", i), 32'(n_rxv - rxv0), 32'd1);
         check($sformatf("v%0d_underrun", i), 32'(und), 32'(vecs[i].exp_und));
         check($sformatf("v%0d_ferr", i), 32'(n_ferr - ferr0), 32'd0);
         check($sformatf("v%0d_ready", i), 32'(tx_ready), 32'd1);
         check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      end

      // Aborted frame after 5 bits, then a clean 0x55 frame.
      lsb_first = 1'b0;
      rxv0  = n_rxv;
      ferr0 = n_ferr;
      frame(8'hFF, 5, 1'b1, m1, und);
      check("abort_ferr", 32'(n_ferr - ferr0), 32'd1);
      check("abort_rxv", 32'(n_rxv - rxv0), 32'd0);
      frame(8'h55, 8, 1'b1, m1, und);
      check("after_abort_rx", 32'(last_rx), 32'h55);
      check("after_abort_rxv", 32'(n_rxv - rxv0), 32'd1);
      check("after_abort_ferr", 32'(n_ferr - ferr0), 32'd1);

      // Back-to-back frames with CS_N held low; second word queued during frame 1.
      rxv0 = n_rxv;
      load_word(8'h11);
      ifc.spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      check("b2b_ready", 32'(tx_ready), 32'd1);
      load_word(8'h22);
      frame(8'hA1, 8, 1'b0, m1, und);
      check("b2b_miso1", 32'(m1), 32'h11);
      check("b2b_rx1", 32'(last_rx), 32'hA1);
      frame(8'hB2, 8, 1'b1, m2, und);
      check("b2b_miso2", 32'(m2), 32'h22);
      check("b2b_rx2", 32'(last_rx), 32'hB2);
      check("b2b_rxv", 32'(n_rxv - rxv0), 32'd2);

      // Asynchronous reset in the middle of a frame.
      ifc.spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      load_word(8'h77);
      frame(8'hF0, 3, 1'b0, m1, und);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_ready", 32'(tx_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(tx_ready), 32'd1);
      check("mid_rst_oe", 32'(ifc.spi_miso_oe), 32'd0);
      check("mid_rst_miso", 32'(ifc.spi_miso), 32'd0);
      check("mid_rst_rx", 32'(rx_data), 32'd0);
      check("mid_rst_strobes", 32'({rx_valid, tx_underrun, frame_err}), 32'd0);
      ifc.spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready", 32'(tx_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
